xdma_cfg_deframer: RTL and testbench
====================================

Name: xdma_cfg_deframer

Overview:
- Receive side of the XDMA inter-cluster configuration transfer: accepts 512-bit frames arriving from a remote cluster on the FromRemoteCfg path.
- Checks and reassembles a multi-frame cfg message: one first frame followed by (frame_length-1) continuation frames.
- Presents the complete message as one wide output word to the local XDMA control logic, with error reporting for malformed sequences.

Parameters:
- DataWidth, 512, frame width; equals AxiWideDataWidth.
- MaxFrames, 8, maximum frames per message, including the first frame; range 1..15.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- frame_i  in  DataWidth  incoming frame
- frame_valid_i  in  1  frame valid
- frame_ready_o  out  1  frame ready
- cfg_header_o  out  DataWidth  first frame, typed xdma_inter_cluster_cfg_t
- cfg_payload_o  out  (MaxFrames-1)*RemainingPayloadWidth  continuation payloads; frame k occupies slot k-1
- cfg_num_frames_o  out  4  frame_length of the delivered message
- cfg_valid_o  out  1  assembled message valid
- cfg_ready_i  in  1  consumer ready
- busy_o  out  1  high whenever FSM is not IDLE
- err_o  out  1  one-cycle error pulse
- err_code_o  out  2  error cause, valid while err_o is high: 1=bad length, 2=sequence mismatch, 3=dma_type mismatch

Behaviour:
- Reset: FSM=IDLE; all outputs 0 except frame_ready_o=1; header and payload registers 0; frame counter 0.
- Frame layouts:
  - First frame: xdma_inter_cluster_cfg_t.
  - Continuation frame: bit0=dma_type, bits[4:1]=sequence index k (1..frame_length-1), bits[DataWidth-1:5]=payload.
- An input transfer happens when frame_valid_i & frame_ready_o. frame_ready_o = (state != OUTPUT).
- IDLE, on transfer:
  - frame_length==0 or >MaxFrames: drop the frame, err_o=1, code 1, stay in IDLE.
  - Otherwise: latch the frame into header, zero every payload slot, set counter=1.
  - frame_length==1: go to OUTPUT. Else: go to COLLECT.
- COLLECT, on transfer:
  - seq != counter: err_o, code 2.
  - seq matches but bit0 != header dma_type: err_o, code 3. Sequence mismatch takes priority over type mismatch.
  - On either error: discard the partial message, consume the offending frame, return to IDLE.
  - Otherwise: store the payload in slot counter-1 and increment counter. When counter+1 == frame_length, go to OUTPUT.
- OUTPUT:
  - cfg_valid_o=1; header, payload and num_frames are held stable until cfg_ready_i.
  - On handshake: go to IDLE; frame_ready_o rises the next cycle (no bypass).
- Latency: the accepting edge of the last frame is followed by cfg_valid_o high in the next cycle. The minimum message interval is frame_length+1 cycles.
- cfg_valid_o must not depend combinationally on cfg_ready_i. frame_ready_o depends only on state.
- Width rules:
  - counter is 4 bits.
  - Comparisons against frame_length use 4-bit unsigned arithmetic.
  - MaxFrames=15 must not overflow, since counter+1 ≤ 15.
- Simultaneous events: no input is accepted in OUTPUT, so an output handshake and an input frame can never collide.
- Reset mid-message: any partial message is discarded immediately and asynchronously, with no err_o pulse.
- err_o and cfg_valid_o are never high in the same cycle.

Decomposition:
- Shared package xdma_pkg holds:
  - xdma_inter_cluster_cfg_t, frame_length_t, RemainingPayloadWidth.
  - New: xdma_cfg_cont_frame_t, a packed struct {remaining_payload_t payload; frame_length_t seq; logic dma_type}.
  - New: enum xdma_cfg_err_e {ErrNone, ErrLen, ErrSeq, ErrType}.
  - New: localparam XdmaCfgMaxFrames=8.
- No sub-module: a single FSM plus the payload register file. A matching transmitter (xdma_cfg_framer) is a separate block.

Test Plan:
- Single frame: first frame with frame_length=1, dma_type=1, dma_id=4'h3, reader_addr=48'h1000, writer_addr=48'h2000 -> cfg_valid_o next cycle; header fields exact; payload all zero; num_frames=1.
- Three frames: frame_length=3, continuations seq=1 payload=P1 and seq=2 payload=P2, sent back-to-back -> slot0=P1, slot1=P2, slots2..6=0; cfg_valid_o one cycle after the third frame.
- Backpressure: hold cfg_ready_i=0 for 5 cycles -> outputs stable; frame_ready_o=0; a queued frame_valid_i is not consumed until the cycle after the handshake.
- Bad length: frame_length=0, then frame_length=9 (MaxFrames=8) -> two err_o pulses with code 1; FSM stays IDLE; no cfg_valid_o.
- Sequence error: frame_length=4; continuations seq=1 then seq=3 -> err_o with code 2 on the seq=3 frame; FSM back to IDLE; a following valid 1-frame message completes normally.
- Reset mid-message: assert rst_i after the 2nd of 4 frames -> all outputs reset asynchronously; a following 2-frame message delivers only its own payload, with slot1..6 = 0.

Source files
------------

// File: rtl/xdma_pkg.sv
// Shared XDMA types: the inter-cluster cfg frame layouts, error codes and the
// deframer state encoding.
package xdma_pkg;

    localparam int unsigned AxiWideDataWidth      = 512;
    localparam int unsigned XdmaCfgMaxFrames      = 8;
    localparam int unsigned AddrWidth             = 48;
    localparam int unsigned FrameLengthWidth      = 4;
    localparam int unsigned DmaIdWidth            = 4;
    // Continuation frame: dma_type (1) + seq (4) + payload.
    localparam int unsigned RemainingPayloadWidth = AxiWideDataWidth - FrameLengthWidth - 1;
    localparam int unsigned HeaderReservedWidth   =
        AxiWideDataWidth - 2 * AddrWidth - DmaIdWidth - FrameLengthWidth - 1;

    typedef logic [FrameLengthWidth-1:0]      frame_length_t;
    typedef logic [RemainingPayloadWidth-1:0] remaining_payload_t;
    typedef logic [AddrWidth-1:0]             addr_t;

    // First frame. dma_type and frame_length sit in the same low bits as the
    // dma_type and seq fields of a continuation frame.
    typedef struct packed {
        logic [HeaderReservedWidth-1:0] reserved;
        addr_t                          writer_addr;
        addr_t                          reader_addr;
        logic [DmaIdWidth-1:0]          dma_id;
        frame_length_t                  frame_length;
        logic                           dma_type;
    } xdma_inter_cluster_cfg_t;

    // Continuation frame k (1..frame_length-1).
    typedef struct packed {
        remaining_payload_t payload;
        frame_length_t      seq;
        logic               dma_type;
    } xdma_cfg_cont_frame_t;

    typedef enum logic [1:0] {
        ErrNone = 2'd0,
        ErrLen  = 2'd1,
        ErrSeq  = 2'd2,
        ErrType = 2'd3
    } xdma_cfg_err_e;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StOutput  = 2'd2
    } xdma_cfg_state_e;

endpackage

// File: rtl/xdma_cfg_deframer.sv
// Receive side of the XDMA inter-cluster cfg transfer: checks a first frame
// plus (frame_length-1) continuation frames and presents the whole message
// as one wide word, pulsing err_o on malformed sequences.
module xdma_cfg_deframer
    import xdma_pkg::*;
#(
    parameter int unsigned DataWidth = AxiWideDataWidth,
    parameter int unsigned MaxFrames = XdmaCfgMaxFrames
) (
    input  logic                                           clk_i,
    input  logic                                           rst_i,
    input  logic [DataWidth-1:0]                           frame_i,
    input  logic                                           frame_valid_i,
    output logic                                           frame_ready_o,
    output logic [DataWidth-1:0]                           cfg_header_o,
    output logic [(MaxFrames-1)*RemainingPayloadWidth-1:0] cfg_payload_o,
    output logic [3:0]                                     cfg_num_frames_o,
    output logic                                           cfg_valid_o,
    input  logic                                           cfg_ready_i,
    output logic                                           busy_o,
    output logic                                           err_o,
    output logic [1:0]                                     err_code_o
);

    localparam int unsigned NumSlots = MaxFrames - 1;

    xdma_cfg_state_e         state_q;
    frame_length_t           cnt_q;
    xdma_inter_cluster_cfg_t header_q;
    remaining_payload_t      slot_q [NumSlots];
    logic                    err_q;
    xdma_cfg_err_e           err_code_q;

    xdma_inter_cluster_cfg_t hdr_in;
    xdma_cfg_cont_frame_t    cont_in;
    logic                    len_bad;

    // View the incoming frame through both layouts and pre-check the length.
    always_comb begin
        hdr_in  = xdma_inter_cluster_cfg_t'(frame_i);
        cont_in = xdma_cfg_cont_frame_t'(frame_i);
        len_bad = (hdr_in.frame_length == '0) ||
                  (hdr_in.frame_length > frame_length_t'(MaxFrames));
    end

    // Message FSM, frame counter, header/payload registers and error pulse.
    // NOTE: every register here uses <= so all of them update from the same
    // pre-edge values; mixing in = would make results order-dependent.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            header_q   <= '0;
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
            // NOTE: the payload slots are a small register file, not a RAM,
            // so they take the reset and a dropped message leaves no trace.
            for (int i = 0; i < NumSlots; i++) slot_q[i] <= '0;
        end else begin
            err_q      <= 1'b0;
            err_code_q <= ErrNone;
            case (state_q)
                StIdle: begin
                    if (frame_valid_i) begin
                        if (len_bad) begin
                            err_q      <= 1'b1;
                            err_code_q <= ErrLen;
                        end else begin
                            header_q <= hdr_in;
                            cnt_q    <= 4'd1;
                            for (int i = 0; i < NumSlots; i++) slot_q[i] <= '0;
                            state_q  <= (hdr_in.frame_length == 4'd1) ? StOutput : StCollect;
                        end
                    end
                end
                StCollect: begin
                    if (frame_valid_i) begin
                        if (cont_in.seq != cnt_q) begin
                            err_q      <= 1'b1;
                            err_code_q <= ErrSeq;
                            state_q    <= StIdle;
                        end else if (cont_in.dma_type != header_q.dma_type) begin
                            err_q      <= 1'b1;
                            err_code_q <= ErrType;
                            state_q    <= StIdle;
                        end else begin
                            for (int i = 0; i < NumSlots; i++) begin
                                if (cnt_q == frame_length_t'(i + 1)) slot_q[i] <= cont_in.payload;
                            end
                            cnt_q <= cnt_q + 4'd1;
                            if (cnt_q + 4'd1 == header_q.frame_length) state_q <= StOutput;
                        end
                    end
                end
                StOutput: begin
                    if (cfg_ready_i) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Flatten the payload slots; frame k lands in slot k-1.
    always_comb begin
        cfg_payload_o = '0;
        for (int i = 0; i < NumSlots; i++) begin
            cfg_payload_o[i*RemainingPayloadWidth +: RemainingPayloadWidth] = slot_q[i];
        end
    end

    assign frame_ready_o    = (state_q != StOutput);
    assign busy_o           = (state_q != StIdle);
    assign cfg_valid_o      = (state_q == StOutput);
    assign cfg_header_o     = header_q;
    assign cfg_num_frames_o = header_q.frame_length;
    assign err_o            = err_q;
    assign err_code_o       = err_code_q;

endmodule

// File: tb/tb_xdma_cfg_deframer.sv
// Scoreboard bench for xdma_cfg_deframer: stimulus pushes expected messages
// and error codes into queues, a negedge monitor pops and compares them.
module tb_xdma_cfg_deframer;
    import xdma_pkg::*;

    localparam int DW       = AxiWideDataWidth;
    localparam int RPW      = RemainingPayloadWidth;
    localparam int NumSlots = XdmaCfgMaxFrames - 1;
    localparam int PW       = NumSlots * RPW;

    typedef logic [511:0] w_t;
    typedef struct packed {
        logic [3:0]    num;
        logic [PW-1:0] payload;
        logic [DW-1:0] hdr;
    } msg_t;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [DW-1:0] frame_i = '0;
    logic          frame_valid_i = 1'b0;
    logic          frame_ready_o;
    logic [DW-1:0] cfg_header_o;
    logic [PW-1:0] cfg_payload_o;
    logic [3:0]    cfg_num_frames_o;
    logic          cfg_valid_o;
    logic          cfg_ready_i = 1'b0;
    logic          busy_o;
    logic          err_o;
    logic [1:0]    err_code_o;

    int n_checks = 0;
    int n_fail   = 0;

    msg_t       exp_msg_q [$];
    logic [1:0] exp_err_q [$];

    xdma_cfg_deframer dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .frame_i         (frame_i),
        .frame_valid_i   (frame_valid_i),
        .frame_ready_o   (frame_ready_o),
        .cfg_header_o    (cfg_header_o),
        .cfg_payload_o   (cfg_payload_o),
        .cfg_num_frames_o(cfg_num_frames_o),
        .cfg_valid_o     (cfg_valid_o),
        .cfg_ready_i     (cfg_ready_i),
        .busy_o          (busy_o),
        .err_o           (err_o),
        .err_code_o      (err_code_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input w_t act, input w_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic w_t mk_hdr(input logic [3:0] len, input logic typ, input logic [3:0] id,
                                  input logic [47:0] ra, input logic [47:0] wa);
        xdma_inter_cluster_cfg_t c;
        c              = '0;
        c.frame_length = len;
        c.dma_type     = typ;
        c.dma_id       = id;
        c.reader_addr  = ra;
        c.writer_addr  = wa;
        return w_t'(c);
    endfunction

    function automatic w_t mk_cont(input logic [3:0] seq, input logic typ, input remaining_payload_t p);
        xdma_cfg_cont_frame_t c;
        c.payload  = p;
        c.seq      = seq;
        c.dma_type = typ;
        return w_t'(c);
    endfunction

    // Present one frame (inputs change #1 after posedge) and return #1 after
    // the edge on which it was accepted.
    task automatic send(input w_t f, input string name);
        int n;
        n = 0;
        frame_i       = f;
        frame_valid_i = 1'b1;
        while (!frame_ready_o && n < 50) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n >= 50) check({name, "_accept_timeout"}, w_t'(0), w_t'(1));
        @(posedge clk_i); #1;
        frame_valid_i = 1'b0;
    endtask

    // Monitor: compare delivered messages and error pulses against the queues.
    always @(negedge clk_i) begin
        if (err_o) begin
            check("err_valid_excl", w_t'(cfg_valid_o), w_t'(0));
            if (exp_err_q.size() == 0) begin
                check("err_unexpected", w_t'(err_code_o), w_t'(0));
            end else begin
                check("err_code", w_t'(err_code_o), w_t'(exp_err_q.pop_front()));
            end
        end
        if (cfg_valid_o && cfg_ready_i) begin
            if (exp_msg_q.size() == 0) begin
                check("msg_unexpected", w_t'(cfg_valid_o), w_t'(0));
            end else begin
                msg_t m;
                m = exp_msg_q.pop_front();
                check("msg_header", w_t'(cfg_header_o), w_t'(m.hdr));
                check("msg_num", w_t'(cfg_num_frames_o), w_t'(m.num));
                for (int i = 0; i < NumSlots; i++) begin
                    check($sformatf("msg_slot%0d", i), w_t'(cfg_payload_o[i*RPW +: RPW]),
                          w_t'(m.payload[i*RPW +: RPW]));
                end
            end
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        msg_t m;
        w_t   h, hb;
        remaining_payload_t p1, p2, p3;
        p1 = remaining_payload_t'(64'hDEAD_BEEF_0000_1111);
        p2 = (remaining_payload_t'(1) << 500) | remaining_payload_t'(16'h0022);
        p3 = remaining_payload_t'(32'hCAFE_F00D);

        // Reset state
        #3;
        check("rst_frame_ready", w_t'(frame_ready_o), w_t'(1));
        check("rst_cfg_valid", w_t'(cfg_valid_o), w_t'(0));
        check("rst_busy", w_t'(busy_o), w_t'(0));
        check("rst_err", w_t'(err_o), w_t'(0));
        check("rst_header", w_t'(cfg_header_o), w_t'(0));
        check("rst_payload_slot0", w_t'(cfg_payload_o[RPW-1:0]), w_t'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        cfg_ready_i = 1'b1;

        // Single-frame message
        h = mk_hdr(4'd1, 1'b1, 4'h3, 48'h1000, 48'h2000);
        m = '0; m.hdr = h; m.num = 4'd1;
        exp_msg_q.push_back(m);
        send(h, "single");
        check("single_latency_valid", w_t'(cfg_valid_o), w_t'(1));
        check("single_frame_ready_low", w_t'(frame_ready_o), w_t'(0));

        // Three frames back-to-back
        h = mk_hdr(4'd3, 1'b0, 4'h5, 48'hABCD_0000, 48'h1234_5678);
        m = '0; m.hdr = h; m.num = 4'd3;
        m.payload[0*RPW +: RPW] = p1;
        m.payload[1*RPW +: RPW] = p2;
        exp_msg_q.push_back(m);
        send(h, "three_hdr");
        check("three_busy", w_t'(busy_o), w_t'(1));
        send(mk_cont(4'd1, 1'b0, p1), "three_c1");
        check("three_not_yet_valid", w_t'(cfg_valid_o), w_t'(0));
        send(mk_cont(4'd2, 1'b0, p2), "three_c2");
        check("three_latency_valid", w_t'(cfg_valid_o), w_t'(1));

        // Backpressure: hold message A, queue frame B behind it
        @(posedge clk_i); #1;
        cfg_ready_i = 1'b0;
        h  = mk_hdr(4'd1, 1'b1, 4'h9, 48'h0000_AAAA, 48'h0000_BBBB);
        hb = mk_hdr(4'd1, 1'b0, 4'hA, 48'h0000_CCCC, 48'h0000_DDDD);
        m = '0; m.hdr = h;  m.num = 4'd1; exp_msg_q.push_back(m);
        m = '0; m.hdr = hb; m.num = 4'd1; exp_msg_q.push_back(m);
        send(h, "bp_a");
        frame_i       = hb;
        frame_valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            check($sformatf("bp_hold%0d_ready", i), w_t'(frame_ready_o), w_t'(0));
            check($sformatf("bp_hold%0d_valid", i), w_t'(cfg_valid_o), w_t'(1));
            check($sformatf("bp_hold%0d_header", i), w_t'(cfg_header_o), h);
        end
        cfg_ready_i = 1'b1;
        @(posedge clk_i); #1;
        check("bp_after_hs_ready", w_t'(frame_ready_o), w_t'(1));
        check("bp_after_hs_valid", w_t'(cfg_valid_o), w_t'(0));
        check("bp_b_not_consumed", w_t'(busy_o), w_t'(0));
        @(posedge clk_i); #1;
        frame_valid_i = 1'b0;
        check("bp_b_valid", w_t'(cfg_valid_o), w_t'(1));
        check("bp_b_header", w_t'(cfg_header_o), hb);

        // Bad lengths 0 and 9
        exp_err_q.push_back(2'd1);
        exp_err_q.push_back(2'd1);
        send(mk_hdr(4'd0, 1'b0, 4'h1, 48'h1, 48'h2), "len0");
        check("len0_err", w_t'(err_o), w_t'(1));
        check("len0_code", w_t'(err_code_o), w_t'(1));
        check("len0_idle", w_t'(busy_o), w_t'(0));
        send(mk_hdr(4'd9, 1'b0, 4'h1, 48'h1, 48'h2), "len9");
        check("len9_err", w_t'(err_o), w_t'(1));
        check("len9_code", w_t'(err_code_o), w_t'(1));
        check("len9_idle", w_t'(busy_o), w_t'(0));
        check("len9_no_valid", w_t'(cfg_valid_o), w_t'(0));

        // Sequence error: seq=1 then seq=3 on a 4-frame message
        exp_err_q.push_back(2'd2);
        send(mk_hdr(4'd4, 1'b0, 4'h2, 48'h10, 48'h20), "seq_hdr");
        send(mk_cont(4'd1, 1'b0, p1), "seq_c1");
        check("seq_c1_no_err", w_t'(err_o), w_t'(0));
        send(mk_cont(4'd3, 1'b0, p2), "seq_c3");
        check("seq_err", w_t'(err_o), w_t'(1));
        check("seq_code", w_t'(err_code_o), w_t'(2));
        check("seq_idle", w_t'(busy_o), w_t'(0));

        // Type mismatch, then seq+type both wrong (sequence wins)
        exp_err_q.push_back(2'd3);
        exp_err_q.push_back(2'd2);
        send(mk_hdr(4'd2, 1'b1, 4'h2, 48'h10, 48'h20), "type_hdr");
        send(mk_cont(4'd1, 1'b0, p1), "type_c1");
        check("type_code", w_t'(err_code_o), w_t'(3));
        send(mk_hdr(4'd3, 1'b1, 4'h2, 48'h10, 48'h20), "prio_hdr");
        send(mk_cont(4'd2, 1'b0, p1), "prio_c2");
        check("prio_code", w_t'(err_code_o), w_t'(2));

        // Recovery with a normal 1-frame message
        h = mk_hdr(4'd1, 1'b0, 4'h7, 48'h7777, 48'h8888);
        m = '0; m.hdr = h; m.num = 4'd1;
        exp_msg_q.push_back(m);
        send(h, "recover");
        check("recover_valid", w_t'(cfg_valid_o), w_t'(1));

        // Reset mid-message, then a 2-frame message
        send(mk_hdr(4'd4, 1'b0, 4'h4, 48'h40, 48'h50), "rmid_hdr");
        send(mk_cont(4'd1, 1'b0, p1), "rmid_c1");
        #2;
        rst_i = 1'b1;
        #1;
        check("rmid_busy", w_t'(busy_o), w_t'(0));
        check("rmid_header", w_t'(cfg_header_o), w_t'(0));
        check("rmid_slot0", w_t'(cfg_payload_o[RPW-1:0]), w_t'(0));
        check("rmid_frame_ready", w_t'(frame_ready_o), w_t'(1));
        check("rmid_err", w_t'(err_o), w_t'(0));
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        h = mk_hdr(4'd2, 1'b1, 4'hC, 48'hC0C0, 48'hD0D0);
        m = '0; m.hdr = h; m.num = 4'd2;
        m.payload[0*RPW +: RPW] = p3;
        exp_msg_q.push_back(m);
        send(h, "post_hdr");
        send(mk_cont(4'd1, 1'b1, p3), "post_c1");
        check("post_valid", w_t'(cfg_valid_o), w_t'(1));

        repeat (4) @(posedge clk_i);
        #1;
        check("sb_msgs_drained", w_t'(exp_msg_q.size()), w_t'(0));
        check("sb_errs_drained", w_t'(exp_err_q.size()), w_t'(0));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
